// File: rtl/sel_pkg.sv
// Shared select-bus definitions: code widths, the "no selection" code, FSM states
// and the legal-code check used by both the decoder and the encoder's bench.
package sel_pkg;

    localparam int SEL_W = 5;
    localparam int BUS_W = 32;
    localparam logic [SEL_W-1:0] SEL_NONE = 5'd31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } sel_state_t;

    function automatic logic sel_is_legal(input logic [SEL_W-1:0] code, input int valid_max);
        return (int'(code) <= valid_max);
    endfunction

endpackage

// File: rtl/dec_5_32_comb.sv
// Pure combinational 5-to-32 one-hot decode; zero latency, no flow control.
module dec_5_32_comb
    import sel_pkg::*;
(
    input  logic [SEL_W-1:0] i_code,
    output logic [BUS_W-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        o_onehot[i_code] = 1'b1;
    end

endmodule

// File: rtl/sel_decoder_5_32.sv
// Registered 5-to-32 select decoder: 1-cycle latency, holds each selection HOLD_CYCLES
// then one idle gap; requests are only consumed (sel_ack) in IDLE, held off while busy.
module sel_decoder_5_32
    import sel_pkg::*;
#(
    parameter int HOLD_CYCLES = 1,
    parameter int VALID_MAX   = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] sel_code,
    input  logic             sel_valid,
    input  logic             err_clr,
    output logic             sel_ack,
    output logic [BUS_W-1:0] dec_out,
    output logic             dec_valid,
    output logic             busy,
    output logic             err
);

    localparam int CNT_RAW = $clog2(HOLD_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

    sel_state_t       r_state;
    sel_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [BUS_W-1:0] r_dec;
    logic [BUS_W-1:0] w_dec_nxt;
    logic [BUS_W-1:0] w_onehot;
    logic             r_dec_vld;
    logic             r_ack;
    logic             w_ack_nxt;
    logic             r_busy;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_legal;

    dec_5_32_comb u_dec (
        .i_code   (sel_code),
        .o_onehot (w_onehot)
    );

    // SEL_NONE is never legal because VALID_MAX is capped at 30.
    assign w_legal = sel_is_legal(sel_code, VALID_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_dec     <= '0;
            r_dec_vld <= 1'b0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dec     <= w_dec_nxt;
            r_dec_vld <= |w_dec_nxt;
            r_ack     <= w_ack_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (sel_valid && w_legal) w_state_nxt = DRIVE;
            DRIVE:   if (r_cnt == '0) w_state_nxt = GAP;
            GAP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_dec_nxt = r_dec;
        w_cnt_nxt = r_cnt;
        w_ack_nxt = 1'b0;
        w_err_nxt = r_err & ~err_clr;
        case (r_state)
            IDLE: begin
                w_dec_nxt = '0;
                if (sel_valid) begin
                    w_ack_nxt = 1'b1;
                    if (w_legal) begin
                        w_dec_nxt = w_onehot;
                        w_cnt_nxt = CNT_W'(HOLD_CYCLES - 1);
                    end else if (sel_code != SEL_NONE) begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
                else             w_dec_nxt = '0;
            end
            default: w_dec_nxt = '0;
        endcase
    end

    assign sel_ack   = r_ack;
    assign dec_out   = r_dec;
    assign dec_valid = r_dec_vld;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_sel_decoder_5_32.sv
// Directed bench for sel_decoder_5_32 with HOLD_CYCLES=2, VALID_MAX=23.
module tb_sel_decoder_5_32;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  sel_code;
    logic        sel_valid;
    logic        err_clr;
    logic        sel_ack;
    logic [31:0] dec_out;
    logic        dec_valid;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;
    logic mon_en = 1'b0;
    logic prev_ack = 1'b0;

    sel_decoder_5_32 #(.HOLD_CYCLES(2), .VALID_MAX(23)) dut (
        .clk       (clk),
        .reset     (reset),
        .sel_code  (sel_code),
        .sel_valid (sel_valid),
        .err_clr   (err_clr),
        .sel_ack   (sel_ack),
        .dec_out   (dec_out),
        .dec_valid (dec_valid),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  code;
        logic        vld;
        logic        clr;
        logic [31:0] exp_dec;
        logic        exp_ack;
        logic        exp_busy;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One rising edge; returns at the following falling edge with outputs settled.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic chk_all(input string nm, input logic [31:0] e_dec, input logic e_ack,
                           input logic e_busy, input logic e_err);
        chk({nm, " dec_out"}, dec_out, e_dec);
        chk({nm, " dec_valid"}, {31'd0, dec_valid}, {31'd0, (e_dec != 32'd0)});
        chk({nm, " sel_ack"}, {31'd0, sel_ack}, {31'd0, e_ack});
        chk({nm, " busy"}, {31'd0, busy}, {31'd0, e_busy});
        chk({nm, " err"}, {31'd0, err}, {31'd0, e_err});
    endtask

    // Invariants: never multi-hot, never back-to-back acks.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon onehot0", {31'd0, $onehot0(dec_out)}, 32'd1);
            chk("mon ack pair", {31'd0, (sel_ack && prev_ack)}, 32'd0);
        end
        prev_ack = sel_ack;
    end

    initial begin
        logic [31:0] one;
        int last_ack;
        int k;

        //            rst code vld clr exp_dec        ack busy err
        tbl.push_back('{1'b1, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0}); // reset state
        tbl.push_back('{1'b0, 5'd5,  1'b1, 1'b0, 32'h0000_0020, 1'b1, 1'b1, 1'b0}); // code 5 accept
        tbl.push_back('{1'b0, 5'd5,  1'b0, 1'b0, 32'h0000_0020, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd5,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0}); // GAP
        tbl.push_back('{1'b0, 5'd5,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0}); // IDLE
        tbl.push_back('{1'b0, 5'd31, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0}); // no-select
        tbl.push_back('{1'b0, 5'd31, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 5'd27, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1}); // illegal
        tbl.push_back('{1'b0, 5'd27, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 5'd24, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1}); // set beats clr
        tbl.push_back('{1'b0, 5'd24, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0}); // clr alone
        tbl.push_back('{1'b0, 5'd24, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 5'd10, 1'b1, 1'b0, 32'h0000_0400, 1'b1, 1'b1, 1'b0}); // code 10
        tbl.push_back('{1'b0, 5'd10, 1'b0, 1'b0, 32'h0000_0400, 1'b0, 1'b1, 1'b0}); // 2nd DRIVE
        tbl.push_back('{1'b1, 5'd10, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0}); // reset mid-drive
        tbl.push_back('{1'b0, 5'd10, 1'b1, 1'b0, 32'h0000_0400, 1'b1, 1'b1, 1'b0}); // re-accept
        tbl.push_back('{1'b0, 5'd10, 1'b0, 1'b0, 32'h0000_0400, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd10, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'd10, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0});

        reset = 1'b1; sel_code = '0; sel_valid = 1'b0; err_clr = 1'b0;
        cyc();
        mon_en = 1'b1;

        foreach (tbl[i]) begin
            reset     = tbl[i].rst;
            sel_code  = tbl[i].code;
            sel_valid = tbl[i].vld;
            err_clr   = tbl[i].clr;
            cyc();
            chk_all($sformatf("row%0d", i), tbl[i].exp_dec, tbl[i].exp_ack,
                    tbl[i].exp_busy, tbl[i].exp_err);
        end
        reset = 1'b0; err_clr = 1'b0;

        // Requester keeps sel_valid high and switches code right after the ack.
        sel_code = 5'd23; sel_valid = 1'b1;
        cyc(); chk_all("hold a", 32'h0080_0000, 1'b1, 1'b1, 1'b0);
        sel_code = 5'd0;
        cyc(); chk_all("hold b", 32'h0080_0000, 1'b0, 1'b1, 1'b0);
        cyc(); chk_all("hold gap", 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        cyc(); chk_all("hold idle", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        cyc(); chk_all("hold next", 32'h0000_0001, 1'b1, 1'b1, 1'b0);
        sel_valid = 1'b0;
        repeat (3) cyc();
        chk_all("hold drained", 32'h0000_0000, 1'b0, 1'b0, 1'b0);

        // Back-to-back sweep of every legal code.
        sel_valid = 1'b1;
        last_ack = 0;
        for (int c = 0; c <= 23; c++) begin
            sel_code = 5'(c);
            k = 0;
            do begin
                cyc();
                k++;
            end while (!sel_ack && k < 8);
            if (!sel_ack) begin
                chk($sformatf("sweep%0d ack timeout", c), {31'd0, sel_ack}, 32'd1);
            end else begin
                one = 32'd1;
                chk($sformatf("sweep%0d dec", c), dec_out, one << c);
                if (c > 0) chk($sformatf("sweep%0d period", c), 32'(cyc_n - last_ack), 32'd4);
                last_ack = cyc_n;
            end
        end
        sel_valid = 1'b0;
        repeat (4) cyc();
        chk_all("sweep end", 32'h0000_0000, 1'b0, 1'b0, 1'b0);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sel_decoder_5_32.md
Name: sel_decoder_5_32

Overview:
- Registered 5-to-32 select decoder. It is the inverse of the bus-source encoder.
- Converts a 5-bit select code from the control unit into a one-hot drive/enable vector for the 32-slot bus.
- Holds each selection for a programmable number of cycles.
- Enforces one idle (all-zero) cycle between selections so bus drivers break before they make.
- Code 31 is the "no selection" code, consistent with the encoder.
- Codes above VALID_MAX are rejected and flagged.

Parameters:
- HOLD_CYCLES, default 1: cycles dec_out stays asserted per accepted selection. Must be >= 1.
- VALID_MAX, default 23: highest legal select code. Legal range is 0..VALID_MAX, and VALID_MAX <= 30.

Ports:
- clk  in  1: clock. All state updates on the rising edge.
- reset  in  1: synchronous, active-high reset.
- sel_code  in  5: encoded select request.
- sel_valid  in  1: request valid. The requester holds sel_code/sel_valid stable until sel_ack.
- err_clr  in  1: clears the sticky err flag.
- sel_ack  out  1: one-cycle pulse; request consumed.
- dec_out  out  32: one-hot (or zero) registered enable vector.
- dec_valid  out  1: high while dec_out is non-zero.
- busy  out  1: high in DRIVE state. New requests are not accepted.
- err  out  1: sticky illegal-code flag.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - dec_out=0, dec_valid=0, busy=0, sel_ack=0, err=0, hold counter=0, state=IDLE.
  - Reset mid-DRIVE drops dec_out to 0 at that edge. The pending selection is discarded.
- States: IDLE, DRIVE, GAP.
- IDLE, sel_valid=1 sampled at edge k. The response is visible after edge k (1-cycle latency):
  - Code 0..VALID_MAX: dec_out = 1<<sel_code, dec_valid=1, busy=1, sel_ack=1 for one cycle, counter = HOLD_CYCLES-1, next state DRIVE.
  - Code 31: sel_ack=1, dec_out stays 0, no error, state stays IDLE.
  - Code VALID_MAX+1..30: sel_ack=1, err=1 (sticky), dec_out stays 0, state stays IDLE.
- IDLE, sel_valid=0: all outputs hold at 0 except err.
- DRIVE:
  - dec_out is held constant.
  - If counter != 0, decrement.
  - If counter == 0: next edge sets dec_out=0, dec_valid=0, state GAP. busy stays 1.
  - sel_valid is ignored in DRIVE (no ack).
- GAP: exactly one cycle with dec_out=0 and busy=1. Next state IDLE with busy=0.
- Requests are sampled only in IDLE, so consecutive legal selections have a minimum period of HOLD_CYCLES+2 cycles.
- sel_ack never asserts for two consecutive cycles. A requester holding sel_valid after ack is treated as a new request only in the next IDLE cycle.
- err behaviour:
  - err_clr=1 clears err at the edge.
  - If err_clr coincides with an illegal code being accepted, set wins and err stays 1.
  - err does not affect decoding.
- Width and invariants:
  - Hold counter width is $clog2(HOLD_CYCLES+1), minimum 1.
  - dec_out is never multi-hot.
  - dec_valid == |dec_out at all times.
- Outputs are driven directly from registers. No combinational path from inputs to outputs.

Decomposition:
- Shared package `sel_pkg`:
  - Constant SEL_NONE = 5'd31.
  - Constant SEL_W = 5, and bus width 32.
  - State enum {IDLE, DRIVE, GAP}.
  - Legal-code range check function, shared with the encoder's testbench.
- One natural sub-module: `dec_5_32_comb`, a pure combinational 5-to-32 one-hot decode. The FSM instantiates it and registers its output.

Test Plan:
- Run all scenarios with HOLD_CYCLES=2, VALID_MAX=23.
1. Reset, then sel_code=5, sel_valid=1 at edge 1:
   - Edges 1-2: dec_out=32'h00000020, sel_ack pulses after edge 1 only, busy=1.
   - Edge 3: dec_out=0 (GAP).
   - Edge 4: busy=0.
2. sel_valid held high with sel_code=23 then changed to 0 right after ack:
   - dec_out=32'h00800000 for 2 cycles, then 1 zero cycle.
   - Then 32'h00000001. Never multi-hot, never two consecutive acks.
3. sel_code=31 in IDLE: sel_ack pulses, dec_out stays 0, err=0, busy=0.
4. sel_code=27: sel_ack pulses, err=1, dec_out=0. Then err_clr=1 together with sel_code=24: err stays 1. Then err_clr alone: err=0.
5. Reset asserted on the second DRIVE cycle of code 10: dec_out=0, busy=0, state IDLE at that edge. A subsequent request for code 10 is accepted normally.
6. Sweep codes 0..23 back-to-back with sel_valid held high: each dec_out equals 1<<code, and the period is exactly 4 cycles.
